key_sync_source: RTL and testbench
==================================

KEY_SYNC_SOURCE -- requirements
Module: key_sync_source

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning number of buffered key/sync pairs (power of two, 2..16).
REQ-002 The module SHALL have parameter BLOCK_W, default aes_model_pack::BLOCK_SIZE (128), meaning width of one key or one sync.
REQ-003 The module SHALL have port clk, input, 1, meaning the single clock.
REQ-004 The module SHALL have port rst, input, 1, meaning synchronous, active-low reset.
REQ-005 The module SHALL have port load_vld, input, 1, meaning a key/sync pair is offered for buffering.
REQ-006 The module SHALL have port load_rdy, output, 1, meaning the buffer accepts a load this cycle.
REQ-007 The module SHALL have port load_key, input, BLOCK_W, meaning the key to buffer.
REQ-008 The module SHALL have port load_sync, input, BLOCK_W, meaning the sync to buffer.
REQ-009 The module SHALL have port key_and_sync_req, input, 1, meaning level request from the consumer for a new pair.
REQ-010 The module SHALL have port key_and_sync_out, dvr_if source modport, 2*BLOCK_W, meaning outgoing data/valid/ready transfer.
REQ-011 The module SHALL have port fill_level, output, clog2(DEPTH)+1, meaning number of buffered pairs.
REQ-012 The module SHALL have port req_underflow_irq, output, 1, meaning a one-cycle pulse when a request finds the buffer empty.

Function
REQ-013 The module SHALL buffer pairs in a FIFO of DEPTH entries; a load occurs when load_vld and load_rdy are both high at a rising clk edge.
REQ-014 The module SHALL drive load_rdy = (fill_level < DEPTH); at full, load_rdy is 0 and offered pairs are not stored.
REQ-015 The module SHALL pack data as {key, sync}: key in bits [2*BLOCK_W-1:BLOCK_W], sync in [BLOCK_W-1:0].
REQ-016 The FSM SHALL have states IDLE, SEND and HOLD.
REQ-017 In IDLE with key_and_sync_req=1 and fill_level>0, the FSM SHALL pop the head into an output register and enter SEND on the next cycle, so valid rises 1 cycle after the request is seen.
REQ-018 In SEND, the module SHALL hold valid=1 with stable data until ready=1; on the handshake it SHALL go to HOLD with valid=0 on the next cycle.
REQ-019 In HOLD, the FSM SHALL wait for key_and_sync_req=0 and then return to IDLE, so one request level yields exactly one transfer.
REQ-020 In IDLE with key_and_sync_req=1 and fill_level=0, the module SHALL pulse req_underflow_irq for one cycle, enter HOLD, and send nothing.
REQ-021 Simultaneous load and pop SHALL leave fill_level unchanged; a load at full coinciding with a pop SHALL NOT be accepted, because load_rdy is registered from the pre-pop level.
REQ-022 Pointers SHALL wrap modulo DEPTH; fill_level SHALL never exceed DEPTH or drop below 0.
REQ-023 A request deasserted while in SEND SHALL NOT abort the transfer; valid is held until ready.

Reset
REQ-024 When rst=0 at a clk edge, the module SHALL set: FSM=IDLE, FIFO empty, fill_level=0, load_rdy=1 on the following cycle, valid=0, data=0, req_underflow_irq=0.
REQ-025 Reset mid-SEND SHALL drop valid in the next cycle and discard the popped pair.

Configuration
REQ-026 With macro KEY_SYNC_SRC_REPLAY_EN defined, an empty-buffer request SHALL resend the last transmitted pair (all zeros if none since reset) through SEND, and req_underflow_irq SHALL still pulse.
REQ-027 Without KEY_SYNC_SRC_REPLAY_EN, the behaviour of REQ-020 SHALL apply and no last-pair register SHALL be built.

Verification
REQ-028 Scenario: load {key=1, sync=1}, raise req, ready=1 -> valid for exactly 1 cycle with data {128'd1, 128'd1}; fill_level goes 1 -> 0.
REQ-029 Scenario: load {102, 412} and {7, 8}, hold ready=0 for 3 cycles in SEND -> data {102, 412} stays stable; after ready, keep req high -> no second transfer until req toggles.
REQ-030 Scenario: load DEPTH+1 pairs back-to-back -> load_rdy=0 after DEPTH loads, fill_level=4, 5th pair absent from the output sequence.
REQ-031 Scenario: request with an empty buffer -> req_underflow_irq pulses once and valid stays 0; with KEY_SYNC_SRC_REPLAY_EN, the previous pair is resent.
REQ-032 Scenario: load at fill_level=2 in the same cycle as a pop -> fill_level stays 2 and FIFO order is preserved.
REQ-033 Scenario: rst=0 during SEND -> valid=0 the next cycle, fill_level=0, FSM back in IDLE.

Source files
------------

// File: rtl/key_sync_source_if.sv
// ============================================================================
//  Module      : aes_model_pack / dvr_if
//  Description : Shared block-size constant and the data/valid/ready
//                transfer interface used by key_sync_source.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_model_pack;
  // Width of one AES block in bits
  parameter int BLOCK_SIZE = 128;
endpackage

interface dvr_if #(
  parameter int W = 2 * aes_model_pack::BLOCK_SIZE
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  // Producer drives data/valid, consumer answers with ready
  modport source (output data, output valid, input ready);
  modport sink   (input data, input valid, output ready);
endinterface

`default_nettype wire

// File: rtl/key_sync_source.sv
// ============================================================================
//  Module      : key_sync_source
//  Description : Buffers key/sync pairs in a DEPTH-entry FIFO and hands one
//                pair per request level to the consumer over a
//                data/valid/ready link. An empty-buffer request raises a
//                one-cycle req_underflow_irq.
//                Optional macro KEY_SYNC_SRC_REPLAY_EN: an empty-buffer
//                request resends the last transmitted pair instead of
//                sending nothing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_sync_source #(
  parameter int DEPTH   = 4,
  parameter int BLOCK_W = aes_model_pack::BLOCK_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_vld,
  output logic                     load_rdy,
  input  logic [BLOCK_W-1:0]       load_key,
  input  logic [BLOCK_W-1:0]       load_sync,
  input  logic                     key_and_sync_req,
  dvr_if.source                    key_and_sync_out,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     req_underflow_irq
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_PW = 2 * BLOCK_W;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [c_PW-1:0] r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_load_rdy;
  state_t          r_state;
  logic            r_valid;
  logic [c_PW-1:0] r_data;
  logic            r_irq;
`ifdef KEY_SYNC_SRC_REPLAY_EN
  logic [c_PW-1:0] r_last;
`endif

  logic            w_push;
  logic            w_pop;
  logic [c_CW-1:0] w_count_next;

  // A load is taken only against the registered ready, so a load offered at
  // full is refused even when a pop happens on the same edge.
  assign w_push = load_vld & r_load_rdy;
  assign w_pop  = (r_state == IDLE) & key_and_sync_req & (r_count != '0);

  // Next occupancy: simultaneous push and pop cancel out
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_CW'(1);
      2'b01:   w_count_next = r_count - c_CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {load_key, load_sync};
    end
  end

  // Pointers, occupancy and registered load_rdy (pointers wrap naturally)
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_load_rdy <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      r_count    <= w_count_next;
      r_load_rdy <= (w_count_next < c_DEPTH);
    end
  end

  // Request FSM: one transfer (or one underflow pulse) per request level
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_irq   <= 1'b0;
`ifdef KEY_SYNC_SRC_REPLAY_EN
      r_last  <= '0;
`endif
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        IDLE: begin
          if (key_and_sync_req) begin
            if (r_count != '0) begin
              r_data  <= r_mem[r_rd_ptr];
              r_valid <= 1'b1;
              r_state <= SEND;
            end else begin
              r_irq   <= 1'b1;
`ifdef KEY_SYNC_SRC_REPLAY_EN
              r_data  <= r_last;
              r_valid <= 1'b1;
              r_state <= SEND;
`else
              r_state <= HOLD;
`endif
            end
          end
        end
        SEND: begin
          // Request level is ignored here: a started transfer always completes
          if (key_and_sync_out.ready) begin
            r_valid <= 1'b0;
            r_state <= HOLD;
`ifdef KEY_SYNC_SRC_REPLAY_EN
            r_last  <= r_data;
`endif
          end
        end
        HOLD: begin
          if (!key_and_sync_req) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign key_and_sync_out.data  = r_data;
  assign key_and_sync_out.valid = r_valid;
  assign load_rdy               = r_load_rdy;
  assign fill_level             = r_count;
  assign req_underflow_irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_key_sync_source.sv
// ============================================================================
//  Module      : tb_key_sync_source
//  Description : Self-checking bench for key_sync_source (DEPTH=4, 128-bit)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_sync_source;

  localparam int DEPTH = 4;
  localparam int BW    = 128;

  typedef struct {
    logic [BW-1:0] key;
    logic [BW-1:0] sync;
    logic          exp_rdy;
    logic [2:0]    exp_fill;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_vld;
  logic          load_rdy;
  logic [BW-1:0] load_key;
  logic [BW-1:0] load_sync;
  logic          req;
  logic [2:0]    fill_level;
  logic          irq;

  dvr_if #(.W(2*BW)) ks_if ();

  key_sync_source #(.DEPTH(DEPTH), .BLOCK_W(BW)) dut (
    .clk               (clk),
    .rst               (rst),
    .load_vld          (load_vld),
    .load_rdy          (load_rdy),
    .load_key          (load_key),
    .load_sync         (load_sync),
    .key_and_sync_req  (req),
    .key_and_sync_out  (ks_if),
    .fill_level        (fill_level),
    .req_underflow_irq (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [2*BW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [2*BW-1:0] act, input logic [2*BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input logic [BW-1:0] k, input logic [BW-1:0] s);
    load_vld  = 1'b1;
    load_key  = k;
    load_sync = s;
    exp_q.push_back({k, s});
    tick();
    load_vld  = 1'b0;
  endtask

  task automatic pull(input string name);
    req         = 1'b1;
    ks_if.ready = 1'b1;
    tick();
    chk(name, 256'(ks_if.valid), 256'(1));
    tick();
    req = 1'b0;
    tick();
  endtask

  // Scoreboard: every handshake must match the oldest expected pair
  always @(negedge clk) begin
    if (rst === 1'b1 && ks_if.valid === 1'b1 && ks_if.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: actual=%0h required=none", ks_if.data);
      end else begin
        chk("xfer_data", ks_if.data, exp_q.pop_front());
      end
    end
  end

  vec_t tbl[5];

  initial begin
    tbl[0] = '{key: 128'd100, sync: 128'd200, exp_rdy: 1'b1, exp_fill: 3'd1};
    tbl[1] = '{key: 128'd101, sync: 128'd201, exp_rdy: 1'b1, exp_fill: 3'd2};
    tbl[2] = '{key: 128'd102, sync: 128'd202, exp_rdy: 1'b1, exp_fill: 3'd3};
    tbl[3] = '{key: 128'd103, sync: 128'd203, exp_rdy: 1'b1, exp_fill: 3'd4};
    tbl[4] = '{key: 128'd104, sync: 128'd204, exp_rdy: 1'b0, exp_fill: 3'd4};

    rst = 1'b0; load_vld = 1'b0; load_key = '0; load_sync = '0;
    req = 1'b0; ks_if.ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_fill", 256'(fill_level), 256'(0));
    chk("rst_load_rdy", 256'(load_rdy), 256'(1));
    chk("rst_valid", 256'(ks_if.valid), 256'(0));
    chk("rst_data", ks_if.data, 256'(0));
    chk("rst_irq", 256'(irq), 256'(0));

    // Single pair, immediate ready
    load_pair(128'd1, 128'd1);
    chk("s1_fill1", 256'(fill_level), 256'(1));
    req = 1'b1; ks_if.ready = 1'b1;
    tick();
    chk("s1_valid", 256'(ks_if.valid), 256'(1));
    chk("s1_fill0", 256'(fill_level), 256'(0));
    tick();
    chk("s1_valid_drop", 256'(ks_if.valid), 256'(0));
    req = 1'b0;
    tick();

    // Backpressure, then one transfer per request level
    load_pair(128'd102, 128'd412);
    load_pair(128'd7, 128'd8);
    ks_if.ready = 1'b0; req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("s2_hold_valid", 256'(ks_if.valid), 256'(1));
      chk("s2_hold_data", ks_if.data, {128'd102, 128'd412});
      tick();
    end
    ks_if.ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("s2_no_repeat", 256'(ks_if.valid), 256'(0));
      tick();
    end
    chk("s2_fill", 256'(fill_level), 256'(1));
    req = 1'b0;
    tick();
    // Request dropped during SEND must not abort the transfer
    req = 1'b1; ks_if.ready = 1'b0;
    tick();
    req = 1'b0;
    tick();
    chk("s2_send_kept", 256'(ks_if.valid), 256'(1));
    chk("s2_send_data", ks_if.data, {128'd7, 128'd8});
    ks_if.ready = 1'b1;
    tick();
    chk("s2_done", 256'(ks_if.valid), 256'(0));
    tick();

    // Back-to-back loads past full
    load_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_key  = tbl[i].key;
      load_sync = tbl[i].sync;
      chk("s3_load_rdy", 256'(load_rdy), 256'(tbl[i].exp_rdy));
      if (tbl[i].exp_rdy) exp_q.push_back({tbl[i].key, tbl[i].sync});
      tick();
      chk("s3_fill", 256'(fill_level), 256'(tbl[i].exp_fill));
    end
    load_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) pull("s3_drain_valid");
    chk("s3_empty", 256'(fill_level), 256'(0));

    // Empty-buffer request
    req = 1'b1; ks_if.ready = 1'b1;
`ifdef KEY_SYNC_SRC_REPLAY_EN
    exp_q.push_back({128'd103, 128'd203});
`endif
    tick();
    chk("s4_irq_pulse", 256'(irq), 256'(1));
`ifdef KEY_SYNC_SRC_REPLAY_EN
    chk("s4_replay_valid", 256'(ks_if.valid), 256'(1));
`else
    chk("s4_no_valid", 256'(ks_if.valid), 256'(0));
`endif
    tick();
    chk("s4_irq_once", 256'(irq), 256'(0));
    chk("s4_valid_after", 256'(ks_if.valid), 256'(0));
    tick();
    chk("s4_irq_still_low", 256'(irq), 256'(0));
    req = 1'b0;
    tick();

    // Load and pop on the same edge at fill_level 2
    load_pair(128'hA, 128'hA0);
    load_pair(128'hB, 128'hB0);
    load_vld = 1'b1; load_key = 128'hC; load_sync = 128'hC0;
    exp_q.push_back({128'hC, 128'hC0});
    req = 1'b1; ks_if.ready = 1'b0;
    tick();
    load_vld = 1'b0;
    chk("s5_fill_same", 256'(fill_level), 256'(2));
    chk("s5_head_data", ks_if.data, {128'hA, 128'hA0});
    ks_if.ready = 1'b1;
    tick();
    req = 1'b0;
    tick();
    // Load offered at full while a pop happens is refused
    load_pair(128'hD, 128'hD0);
    load_pair(128'hE, 128'hE0);
    chk("s5_full", 256'(fill_level), 256'(4));
    load_vld = 1'b1; load_key = 128'hF; load_sync = 128'hF0;
    req = 1'b1;
    chk("s5_rdy_full", 256'(load_rdy), 256'(0));
    tick();
    load_vld = 1'b0;
    chk("s5_fill_pop", 256'(fill_level), 256'(3));
    tick();
    req = 1'b0;
    tick();
    chk("s5_rdy_back", 256'(load_rdy), 256'(1));
    for (int i = 0; i < 3; i++) pull("s5_drain_valid");

    // Reset during SEND
    load_pair(128'h11, 128'h22);
    load_pair(128'h33, 128'h44);
    req = 1'b1; ks_if.ready = 1'b0;
    tick();
    chk("s6_in_send", 256'(ks_if.valid), 256'(1));
    rst = 1'b0;
    exp_q.delete();
    tick();
    chk("s6_valid_drop", 256'(ks_if.valid), 256'(0));
    chk("s6_fill", 256'(fill_level), 256'(0));
    chk("s6_data", ks_if.data, 256'(0));
    rst = 1'b1; req = 1'b0;
    tick();
    load_pair(128'h55, 128'h66);
    pull("s6_idle_again");

    chk("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
